// File: rtl/alu_32.sv
// alu_32: MIPS-style integer ALU with a single registered result stage.
// One shared adder serves ADD, SUB and SLT; F[2] selects ~B and carry-in 1.
module alu_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       F,
  output logic [WIDTH-1:0] Y,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic             w_less;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_overflow;

  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_carry;
  logic             r_overflow;
  logic             r_out_valid;

  // Shared adder: S = A + Bx + F[2], signed overflow and signed less-than derived from it.
  always_comb begin
    w_bx            = F[2] ? ~B : B;
    {w_cout, w_sum} = {1'b0, A} + {1'b0, w_bx} + {{WIDTH{1'b0}}, F[2]};
    w_ovf           = (A[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
    // XOR with overflow keeps the signed compare correct when A - B wraps
    w_less          = w_sum[WIDTH-1] ^ w_ovf;
  end

  // Function decode; carry/overflow only meaningful for ADD and SUB.
  always_comb begin
    w_y        = '0;
    w_carry    = 1'b0;
    w_overflow = 1'b0;
    unique case (F)
      3'b000: w_y = A & B;
      3'b001: w_y = A | B;
      3'b010: begin
        w_y        = w_sum;
        w_carry    = w_cout;
        w_overflow = w_ovf;
      end
      3'b011: w_y = '0;
      3'b100: w_y = A & w_bx;
      3'b101: w_y = A | w_bx;
      3'b110: begin
        w_y        = w_sum;
        w_carry    = w_cout;
        w_overflow = w_ovf;
      end
      3'b111: w_y = {{(WIDTH-1){1'b0}}, w_less};
      default: w_y = '0;
    endcase
  end

  // Result register: reset wins, loads on in_valid, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_y        <= w_y;
        r_zero     <= (w_y == '0);
        r_carry    <= w_carry;
        r_overflow <= w_overflow;
      end
    end
  end

  assign Y         = r_y;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_alu_32.sv
// tb_alu_32: directed-vector bench for alu_32 with hand-computed expectations.
module tb_alu_32;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] A;
  logic [31:0] B;
  logic [2:0]  F;
  logic [31:0] Y;
  logic        zero;
  logic        carry;
  logic        overflow;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  alu_32 #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .F        (F),
    .Y        (Y),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation, advance one edge, settle 1 time unit past it.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f);
    in_valid = v;
    A        = a;
    B        = b;
    F        = f;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    drive(1'b0, 32'h0, 32'h0, 3'b000);
    checks++; if (Y !== 32'h0) begin errors++; $display("FAIL reset_y got=%h exp=%h", Y, 32'h0); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", zero); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", out_valid); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", carry, overflow); end
    reset = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 32'h0, 3'b000);
    checks++; if (Y !== 32'h0) begin errors++; $display("FAIL and_y got=%h exp=%h", Y, 32'h0); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL and_zero got=%b exp=1", zero); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL and_vld got=%b exp=1", out_valid); end
  endtask

  task automatic test_logic;
    drive(1'b1, 32'h1234_5678, 32'h8765_4321, 3'b001);
    checks++; if (Y !== 32'h9775_5779) begin errors++; $display("FAIL or_y got=%h exp=%h", Y, 32'h9775_5779); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL or_zero got=%b exp=0", zero); end
    drive(1'b1, 32'h0, 32'h0, 3'b100);
    checks++; if (Y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL andn_y got=%h/%b exp=0/1", Y, zero); end
    drive(1'b1, 32'h0F0F_0F0F, 32'hFFFF_0000, 3'b101);
    checks++; if (Y !== 32'h0F0F_FFFF) begin errors++; $display("FAIL orn_y got=%h exp=%h", Y, 32'h0F0F_FFFF); end
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 3'b011);
    checks++; if (Y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL rsvd_y got=%h/%b exp=0/1", Y, zero); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL rsvd_flags got=%b%b exp=00", carry, overflow); end
  endtask

  task automatic test_add;
    drive(1'b1, 32'h0000_FFFF, 32'hFFFF_0000, 3'b010);
    checks++; if (Y !== 32'hFFFF_FFFF) begin errors++; $display("FAIL add_y got=%h exp=%h", Y, 32'hFFFF_FFFF); end
    checks++; if ({zero, carry, overflow} !== 3'b000) begin errors++; $display("FAIL add_flags got=%b%b%b exp=000", zero, carry, overflow); end
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 3'b010);
    checks++; if (Y !== 32'h8000_0000) begin errors++; $display("FAIL addov_y got=%h exp=%h", Y, 32'h8000_0000); end
    checks++; if ({carry, overflow} !== 2'b01) begin errors++; $display("FAIL addov_flags got=%b%b exp=01", carry, overflow); end
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b010);
    checks++; if ({Y, zero, carry, overflow} !== {32'h0, 3'b110}) begin errors++; $display("FAIL addc got=%h %b%b%b exp=0 110", Y, zero, carry, overflow); end
  endtask

  task automatic test_sub;
    drive(1'b1, 32'h8000_0000, 32'h1, 3'b110);
    checks++; if (Y !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sub_y got=%h exp=%h", Y, 32'h7FFF_FFFF); end
    checks++; if ({carry, overflow} !== 2'b11) begin errors++; $display("FAIL sub_flags got=%b%b exp=11", carry, overflow); end
    drive(1'b1, 32'h1, 32'h2, 3'b110);
    checks++; if ({Y, carry, overflow} !== {32'hFFFF_FFFF, 2'b00}) begin errors++; $display("FAIL borrow got=%h %b%b exp=ffffffff 00", Y, carry, overflow); end
  endtask

  task automatic test_slt;
    drive(1'b1, 32'h8000_0000, 32'h1, 3'b111);
    checks++; if (Y !== 32'h1) begin errors++; $display("FAIL slt_y got=%h exp=%h", Y, 32'h1); end
    checks++; if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL slt_flags got=%b%b exp=00", carry, overflow); end
    drive(1'b1, 32'h1, 32'h8000_0000, 3'b111);
    checks++; if (Y !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL sltsw_y got=%h/%b exp=0/1", Y, zero); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 32'h5, 32'h3, 3'b010);
    checks++; if (Y !== 32'h8 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b0 got=%h/%b exp=8/1", Y, out_valid); end
    drive(1'b1, 32'h5, 32'h3, 3'b110);
    checks++; if (Y !== 32'h2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b1 got=%h/%b exp=2/1", Y, out_valid); end
    drive(1'b1, 32'h5, 32'h3, 3'b000);
    checks++; if (Y !== 32'h1 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b2 got=%h/%b exp=1/1", Y, out_valid); end
  endtask

  task automatic test_hold;
    drive(1'b1, 32'h7FFF_FFFF, 32'h1, 3'b010);
    for (int i = 0; i < 3; i++) begin
      // Garbage on the inputs must be ignored while in_valid is low
      drive(1'b0, 32'h0, 32'h0, 3'b011);
      checks++;
      if ({Y, overflow, zero, out_valid} !== {32'h8000_0000, 3'b100}) begin
        errors++;
        $display("FAIL hold%0d got=%h %b%b%b exp=80000000 100", i, Y, overflow, zero, out_valid);
      end
    end
  endtask

  task automatic test_reset_wins;
    reset = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'h1, 3'b010);
    checks++;
    if ({Y, zero, carry, overflow, out_valid} !== {32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL rstwin got=%h %b%b%b%b exp=0 1000", Y, zero, carry, overflow, out_valid);
    end
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    F        = '0;
    test_reset();
    test_logic();
    test_add();
    test_sub();
    test_slt();
    test_back_to_back();
    test_hold();
    test_reset_wins();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_32.md
Name: alu_32

Overview:
- 32-bit MIPS-style integer ALU with a registered result stage: 3-bit function code F selects AND/OR/ADD/SUB/SLT and complemented-B logic ops.
- Sits in the datapath execute stage.
- Produces result Y plus zero, carry and overflow flags, one clock after a valid operation is presented.

Parameters:
- WIDTH, 32, operand/result width; all behaviour below is stated for 32, and must generalise to any WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  A, B and F are valid this cycle; operation is captured on this edge.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- F  input  3  function select.
- Y  output  WIDTH  registered result.
- zero  output  1  registered; 1 when Y == 0.
- carry  output  1  registered carry-out of the adder for F=010/110, else 0.
- overflow  output  1  registered signed overflow for F=010/110, else 0.
- out_valid  output  1  1 for exactly the cycle after an accepted in_valid.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (sampled on a rising clk edge with reset=1):
  - Y=0, zero=1, carry=0, overflow=0, out_valid=0.
  - Reset overrides in_valid in the same cycle.
- Adder structure:
  - Single adder computes S = A + Bx + F[2], with carry-out Cout.
  - Bx = ~B when F[2]=1, else B.
- Function decode, with Bx as defined above:
  - 000: A & B.
  - 001: A | B.
  - 010: A + B (F[2]=0, so carry-in 0).
  - 011: reserved; Y = 0, carry = 0, overflow = 0.
  - 100: A & ~B.
  - 101: A | ~B.
  - 110: A - B, i.e. A + ~B + 1.
  - 111: SLT; Y = {WIDTH-1 zeros, less}, where less = S[WIDTH-1] XOR ovf_sub. This is a signed compare that is correct under overflow.
- Flags:
  - Signed overflow: ovf = (A[msb] == Bx[msb]) && (S[msb] != A[msb]).
  - For 010/110, carry = Cout and overflow = ovf.
  - For all other codes (including 111), carry and overflow are 0.
  - For 110, carry=1 means no borrow (A >= B unsigned).
- Arithmetic: all ops are modulo 2^WIDTH; wrap-around is silent apart from the flags.
- Latency:
  - When in_valid=1 on an edge (and reset=0), Y, zero, carry and overflow load the computed values, and out_valid=1 on the next cycle.
  - zero is always consistent with the registered Y.
- When in_valid=0 on an edge: Y, zero, carry and overflow hold their previous values, and out_valid goes 0.
- Back-to-back: in_valid may be high every cycle; throughput is 1 op/cycle. There is no backpressure and no stall input.
- Inputs are sampled only at edges where in_valid=1; changes to A, B or F between edges have no effect.
- Reset mid-stream: a pending result is discarded and the outputs take their reset values.

Test Plan:
- Reset, then in_valid with A=FFFFFFFF, B=00000000, F=000:
  - after reset: Y=0, zero=1, out_valid=0;
  - next cycle: Y=00000000, zero=1, out_valid=1.
- A=12345678, B=87654321, F=001 -> Y=97755779, zero=0.
- A=0000FFFF, B=FFFF0000, F=010 -> Y=FFFFFFFF, carry=0, overflow=0, zero=0.
- A=7FFFFFFF, B=00000001, F=010 -> Y=80000000, overflow=1, carry=0.
- Subtract: A=80000000, B=00000001, F=110 -> Y=7FFFFFFF, overflow=1, carry=1.
- Reserved and AND-NOT:
  - A=80000000, B=80000000, F=011 -> Y=0, zero=1.
  - A=0, B=0, F=100 -> Y=0, zero=1.
- SLT: A=80000000, B=00000001, F=111 -> Y=00000001. Swapped operands -> Y=0.
- Hold and reset behaviour:
  - in_valid=0 for 3 cycles -> Y holds, out_valid=0.
  - Assert reset with in_valid=1 -> reset values win.
